// File: rtl/mem_map_pkg.sv
// Shared definitions for the data-side memory subsystem: MMIO register
// offsets, store-width encodings, STATUS bit positions, the UART TX state
// enum and a helper that turns a store width plus address into byte lanes.
package mem_map_pkg;

  // MMIO register offsets, matched against addr[3:0]
  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CLKDIV = 4'h8;

  // Store widths, funct3 encoding
  localparam logic [2:0] WT_BYTE = 3'b000;
  localparam logic [2:0] WT_HALF = 3'b001;
  localparam logic [2:0] WT_WORD = 3'b010;

  // STATUS register bit positions
  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_ERR_ALIGN = 3;
  localparam int ST_ERR_OVF   = 4;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Byte-lane enables for a store. Zero means the store is dropped
  // (misaligned half/word or an unsupported width code).
  function automatic logic [3:0] store_lanes(input logic [2:0] wt,
                                             input logic [1:0] a);
    logic [3:0] be;
    be = 4'b0000;
    case (wt)
      WT_BYTE: be = 4'b0001 << a;
      WT_HALF: if (!a[0]) be = a[1] ? 4'b1100 : 4'b0011;
      WT_WORD: if (a == 2'b00) be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// UART transmitter with TX FIFO, 8N1, idle high.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   i_push        push strobe, i_push_data the byte to queue
//   i_clkdiv      baud divisor (>= 1), latched at each START
//   o_push_drop   push was refused (FIFO full and no pop this cycle)
//   o_count, o_full, o_empty  FIFO occupancy before the current edge
//   o_state       FSM state (debug / busy derivation)
//   o_tx          registered serial output
// Push handshake: i_push is a single-cycle request with no back-pressure;
// it is accepted when count < FIFO_DEPTH or a pop happens in the same cycle,
// otherwise it is dropped and o_push_drop is high for that cycle.
module uart_tx_core
  import mem_map_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = PW + 1
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [7:0]    i_push_data,
  input  logic [15:0]   i_clkdiv,
  output logic          o_push_drop,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty,
  output tx_state_e     o_state,
  output logic          o_tx
);

  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  tx_state_e     r_state;
  logic [15:0]   r_div;
  logic [15:0]   r_timer;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_tx;

  logic w_pop;
  logic w_push_ok;
  logic w_timer_done;

  // The FSM only takes a byte from IDLE, so at most one pop per frame.
  assign w_pop        = (r_state == TX_IDLE) && (r_count != '0);
  assign w_push_ok    = i_push && ((r_count < CW'(FIFO_DEPTH)) || w_pop);
  assign o_push_drop  = i_push && !w_push_ok;
  assign w_timer_done = (r_timer == 16'd0);

  assign o_count = r_count;
  assign o_full  = (r_count == CW'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_state = r_state;
  assign o_tx    = r_tx;

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Every phase lasts r_div cycles: the timer is loaded with div-1 on entry
  // and the phase ends on the edge where it reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= TX_IDLE;
      r_div     <= 16'd1;
      r_timer   <= 16'd0;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'd0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        TX_IDLE: begin
          if (w_pop) begin
            r_state <= TX_START;
            r_shift <= r_fifo[r_rd_ptr];
            r_div   <= i_clkdiv;
            r_timer <= i_clkdiv - 16'd1;
            r_tx    <= 1'b0;
          end
        end
        TX_START: begin
          if (w_timer_done) begin
            r_state   <= TX_DATA;
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_cnt <= 3'd0;
            r_timer   <= r_div - 16'd1;
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        TX_DATA: begin
          if (w_timer_done) begin
            r_timer <= r_div - 16'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= TX_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        TX_STOP: begin
          if (w_timer_done) r_state <= TX_IDLE;
          else              r_timer <= r_timer - 16'd1;
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_mmio.sv
// Data-side memory subsystem behind the core's MEM stage: data RAM with
// byte/half/word stores plus a 16-byte MMIO window (UART TXDATA, STATUS,
// CLKDIV). No wait states: reads are combinational, writes commit on the
// rising edge with mem_write=1.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   mem_write       store strobe
//   write_type      store width (byte/half/word, other codes dropped)
//   mem_addr        byte address for loads and stores
//   mem_write_data  store value, right-aligned
//   mem_read_data   combinational read word
//   uart_tx         serial output
module data_mem_mmio
  import mem_map_pkg::*;
#(
  parameter int          RAM_WORDS    = 4096,
  parameter logic [31:0] MMIO_BASE    = 32'h1000_0000,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [15:0] CLKDIV_RESET = 16'd868
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_write,
  input  logic [2:0]  write_type,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        uart_tx
);

  localparam int          RAM_AW    = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) * 32'd4;
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;

  logic [31:0] r_ram [RAM_WORDS];
  logic [15:0] r_clkdiv;
  logic        r_err_align;
  logic        r_err_ovf;

  logic              w_is_ram;
  logic              w_is_mmio;
  logic [3:0]        w_off;
  logic [RAM_AW-1:0] w_ram_idx;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic              w_ram_we;
  logic              w_mmio_wr;
  logic              w_align_err;
  logic              w_push;
  logic              w_push_drop;
  logic              w_clr_align;
  logic              w_clr_ovf;
  logic              w_clkdiv_we;
  logic [CW-1:0]     w_count;
  logic              w_full;
  logic              w_empty;
  tx_state_e         w_tx_state;
  logic              w_tx_busy;
  logic [31:0]       w_status;

  assign w_is_ram  = (mem_addr < RAM_BYTES);
  assign w_is_mmio = (mem_addr[31:4] == MMIO_BASE[31:4]);
  assign w_off     = mem_addr[3:0];
  assign w_ram_idx = mem_addr[RAM_AW+1:2];
  assign w_be      = store_lanes(write_type, mem_addr[1:0]);

  // Replicate the low byte/half across the word; w_be picks the lane.
  always_comb begin
    w_wdata = mem_write_data;
    case (write_type)
      WT_BYTE: w_wdata = {4{mem_write_data[7:0]}};
      WT_HALF: w_wdata = {2{mem_write_data[15:0]}};
      default: w_wdata = mem_write_data;
    endcase
  end

  assign w_ram_we  = mem_write && w_is_ram && (w_be != 4'b0000);
  assign w_mmio_wr = mem_write && w_is_mmio;

  assign w_align_err = mem_write &&
      ((w_is_ram && (((write_type == WT_HALF) && mem_addr[0]) ||
                     ((write_type == WT_WORD) && (mem_addr[1:0] != 2'b00)))) ||
       (w_is_mmio && (mem_addr[1:0] != 2'b00)));

  // Offsets are exact 4-bit matches, so these are aligned by construction.
  assign w_push      = w_mmio_wr && (w_off == OFF_TXDATA);
  assign w_clkdiv_we = w_mmio_wr && (w_off == OFF_CLKDIV);
  assign w_clr_align = w_mmio_wr && (w_off == OFF_STATUS) && mem_write_data[ST_ERR_ALIGN];
  assign w_clr_ovf   = w_mmio_wr && (w_off == OFF_STATUS) && mem_write_data[ST_ERR_OVF];

  // RAM contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_ram[w_ram_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  // Error flags: a new event in the same cycle as a W1C clear wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clkdiv    <= CLKDIV_RESET;
      r_err_align <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      if (w_clkdiv_we) begin
        r_clkdiv <= (mem_write_data[15:0] == 16'd0) ? 16'd1 : mem_write_data[15:0];
      end
      if (w_align_err)      r_err_align <= 1'b1;
      else if (w_clr_align) r_err_align <= 1'b0;
      if (w_push_drop)      r_err_ovf <= 1'b1;
      else if (w_clr_ovf)   r_err_ovf <= 1'b0;
    end
  end

  uart_tx_core #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_uart_tx_core (
    .clk         (clk),
    .rst_n       (rst),
    .i_push      (w_push),
    .i_push_data (mem_write_data[7:0]),
    .i_clkdiv    (r_clkdiv),
    .o_push_drop (w_push_drop),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_state     (w_tx_state),
    .o_tx        (uart_tx)
  );

  assign w_tx_busy = (w_tx_state != TX_IDLE);

  always_comb begin
    w_status                      = 32'd0;
    w_status[ST_FULL]             = w_full;
    w_status[ST_EMPTY]            = w_empty;
    w_status[ST_BUSY]             = w_tx_busy;
    w_status[ST_ERR_ALIGN]        = r_err_align;
    w_status[ST_ERR_OVF]          = r_err_ovf;
    w_status[ST_COUNT_LSB +: CW]  = w_count;
  end

  always_comb begin
    mem_read_data = 32'd0;
    if (w_is_ram) begin
      mem_read_data = r_ram[w_ram_idx];
    end else if (w_is_mmio) begin
      case (w_off)
        OFF_STATUS: mem_read_data = w_status;
        OFF_CLKDIV: mem_read_data = {16'd0, r_clkdiv};
        default:    mem_read_data = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench for data_mem_mmio. Drivers push expected responses into
// exp_q; one negedge monitor pops and compares them, and also decodes every
// UART frame sample-by-sample against uart_q.
module tb_data_mem_mmio;

  localparam logic [31:0] A_TX  = 32'h1000_0000;
  localparam logic [31:0] A_ST  = 32'h1000_0004;
  localparam logic [31:0] A_DIV = 32'h1000_0008;
  localparam logic [31:0] A_RSV = 32'h1000_000C;
  localparam logic [2:0]  T_B = 3'b000, T_H = 3'b001, T_W = 3'b010;

  // scoreboard entry kinds
  localparam logic [2:0] K_RD = 3'd0, K_TX = 3'd1, K_IDLE = 3'd2,
                         K_GAP = 3'd3, K_NFR = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  write_type = 3'd0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_write_data = 32'd0;
  logic [31:0] mem_read_data;
  logic        uart_tx;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [34:0] exp_q[$];
  string       name_q[$];
  logic        rd_pend = 1'b0;
  logic [23:0] uart_q[$];     // {divisor, data byte}
  int          start_cyc[$];

  logic        mon_active = 1'b0;
  logic [23:0] mon_frame = 24'd0;
  int          mon_idx = 0;
  int          mon_bad = 0;
  int          m_div, m_b;
  logic        m_expb;
  logic [34:0] m_e;
  logic [31:0] m_act;
  string       m_nm;

  data_mem_mmio dut (
    .clk            (clk),
    .rst            (rst),
    .mem_write      (mem_write),
    .write_type     (write_type),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .uart_tx        (uart_tx)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 500000 ns");
    $fatal(1);
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && (uart_tx === 1'b0)) begin
        if (uart_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL uart_start: start bit at cycle %0d, expected no frame", cyc);
          mon_frame = {16'd4, 8'h00};
        end else begin
          mon_frame = uart_q.pop_front();
        end
        mon_active = 1'b1;
        mon_idx    = 0;
        mon_bad    = 0;
        start_cyc.push_back(cyc);
      end
      if (mon_active) begin
        m_div = int'(mon_frame[23:8]);
        m_b   = mon_idx / m_div;
        if (m_b == 0)      m_expb = 1'b0;
        else if (m_b <= 8) m_expb = mon_frame[m_b-1];
        else               m_expb = 1'b1;
        if (uart_tx !== m_expb) mon_bad++;
        mon_idx++;
        if (mon_idx == 10 * m_div) begin
          checks++;
          if (mon_bad != 0) begin
            errors++;
            $display("FAIL uart_frame %02h: got %0d wrong samples, expected 0",
                     mon_frame[7:0], mon_bad);
          end
          mon_active = 1'b0;
        end
      end
    end

    if (rd_pend) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: got empty queue, expected an entry");
      end else begin
        m_e  = exp_q.pop_front();
        m_nm = name_q.pop_front();
        case (m_e[34:32])
          K_RD:   m_act = mem_read_data;
          K_TX:   m_act = {31'd0, uart_tx};
          K_IDLE: m_act = {31'd0, (uart_q.size() == 0) && !mon_active};
          K_GAP: begin
            m_act = m_e[31:0];
            for (int i = 1; i < start_cyc.size(); i++) begin
              if (start_cyc[i] - start_cyc[i-1] != int'(m_e[31:0]))
                m_act = 32'(start_cyc[i] - start_cyc[i-1]);
            end
          end
          K_NFR:  m_act = 32'(start_cyc.size());
          default: m_act = 32'hFFFF_FFFF;
        endcase
        if (m_act !== m_e[31:0]) begin
          errors++;
          $display("FAIL %s: got %08h expected %08h", m_nm, m_act, m_e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_item(input logic [2:0] kind, input logic [31:0] v, input string nm);
    exp_q.push_back({kind, v});
    name_q.push_back(nm);
    rd_pend = 1'b1;
    @(posedge clk);
    #1;
    rd_pend = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    mem_write = 1'b0;
    mem_addr  = a;
    expect_item(K_RD, e, nm);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] wt);
    mem_addr       = a;
    mem_write_data = d;
    write_type     = wt;
    mem_write      = 1'b1;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && !((uart_q.size() == 0) && !mon_active); i++) idle(1);
    expect_item(K_IDLE, 32'd1, "uart_drained");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle(2);
    expect_item(K_TX, 32'd1, "tx_in_reset");
    rst = 1'b1;
    rd(A_ST,  32'h0000_0002, "status_reset");
    rd(A_DIV, 32'h0000_0364, "clkdiv_reset");

    // RAM lanes
    wr(32'h100, 32'hDEAD_BEEF, T_W);
    wr(32'h102, 32'hFFFF_FF55, T_B);
    rd(32'h100, 32'hDE55_BEEF, "sb_lane2");
    wr(32'h101, 32'h0000_1234, T_H);
    rd(32'h100, 32'hDE55_BEEF, "sh_misaligned_dropped");
    rd(A_ST,    32'h0000_000A, "err_align_set");
    wr(A_ST,    32'h0000_0008, T_W);
    rd(A_ST,    32'h0000_0002, "err_align_w1c");
    wr(32'h102, 32'hFFFF_ABCD, T_H);
    rd(32'h103, 32'hABCD_BEEF, "sh_upper_half");
    wr(32'h103, 32'h0000_0077, T_B);
    rd(32'h100, 32'h77CD_BEEF, "sb_lane3");
    wr(32'h100, 32'h1111_1111, 3'b011);
    rd(32'h100, 32'h77CD_BEEF, "bad_width_dropped");
    rd(A_ST,    32'h0000_0002, "bad_width_no_err");
    wr(32'h104, 32'h0000_0000, T_W);
    wr(32'h106, 32'h0000_CAFE, T_W);
    rd(32'h104, 32'h0000_0000, "sw_misaligned_dropped");
    rd(A_ST,    32'h0000_000A, "sw_misaligned_err");
    wr(A_ST,    32'h0000_0008, T_W);

    // MMIO registers
    wr(32'h1000_0009, 32'h0000_0005, T_W);
    rd(A_DIV, 32'h0000_0364, "mmio_misaligned_dropped");
    rd(A_ST,  32'h0000_000A, "mmio_misaligned_err");
    wr(A_ST,  32'h0000_0008, T_W);
    wr(A_DIV, 32'h0000_0000, T_W);
    rd(A_DIV, 32'h0000_0001, "clkdiv_zero_to_one");
    wr(A_DIV, 32'hFFFF_0004, T_W);
    rd(A_DIV, 32'h0000_0004, "clkdiv_4");

    // RAM boundary and unmapped space
    wr(32'h3FFC, 32'hA5A5_0001, T_W);
    rd(32'h3FFC, 32'hA5A5_0001, "ram_top_word");
    wr(32'h0, 32'h0000_0000, T_W);
    wr(32'h4000, 32'hFFFF_FFFF, T_W);
    wr(32'h2000_0000, 32'h1234_5678, T_W);
    rd(32'h4000, 32'h0000_0000, "past_ram_reads_0");
    rd(32'h2000_0000, 32'h0000_0000, "unmapped_reads_0");
    rd(32'h0, 32'h0000_0000, "no_alias_word0");
    rd(32'h100, 32'h77CD_BEEF, "unmapped_no_ram_change");
    wr(A_RSV, 32'h0000_FFFF, T_W);
    rd(A_RSV, 32'h0000_0000, "reserved_reads_0");
    rd(A_TX,  32'h0000_0000, "txdata_reads_0");
    rd(A_ST,  32'h0000_0002, "status_clean");

    // Single frame, divisor 4: start bit appears after the edge following the push
    uart_q.push_back({16'd4, 8'hA5});
    wr(A_TX, 32'h0000_00A5, T_W);
    expect_item(K_TX, 32'd1, "tx_high_push_cycle");
    expect_item(K_TX, 32'd0, "tx_start_next_cycle");
    mem_addr = A_ST;
    for (int j = 0; j < 45; j++) begin
      rd(A_ST, (j <= 38) ? 32'h0000_0006 : 32'h0000_0002, "status_busy_window");
    end
    wait_drain(100);

    // Overflow burst behind a running frame, divisor 2
    wr(A_DIV, 32'h0000_0002, T_W);
    start_cyc.delete();
    uart_q.push_back({16'd2, 8'h5A});
    wr(A_TX, 32'h0000_005A, T_W);
    idle(2);
    for (int k = 0; k < 9; k++) begin
      if (k < 8) uart_q.push_back({16'd2, 8'(8'h10 + k)});
      wr(A_TX, 32'(8'h10 + k), T_B);
    end
    rd(A_ST, 32'h0000_0815, "status_full_ovf");
    wait_drain(400);
    expect_item(K_NFR, 32'd9, "frame_count");
    expect_item(K_GAP, 32'd21, "frame_spacing");
    wr(A_ST, 32'h0000_0010, T_W);
    rd(A_ST, 32'h0000_0002, "err_ovf_w1c");

    // Reset in the middle of a data bit with three bytes queued
    wr(A_DIV, 32'h0000_0004, T_W);
    uart_q.push_back({16'd4, 8'h3C});
    wr(A_TX, 32'h0000_003C, T_B);
    wr(A_TX, 32'h0000_0011, T_B);
    wr(A_TX, 32'h0000_0022, T_B);
    wr(A_TX, 32'h0000_0033, T_B);
    idle(7);
    expect_item(K_TX, 32'd0, "tx_low_mid_data");
    #2;
    rst = 1'b0;
    uart_q.delete();
    expect_item(K_TX, 32'd1, "tx_async_reset");
    idle(1);
    rst = 1'b1;
    rd(A_ST,  32'h0000_0002, "status_after_reset");
    rd(A_DIV, 32'h0000_0364, "clkdiv_after_reset");
    rd(32'h100, 32'h77CD_BEEF, "ram_kept_over_reset");
    idle(60);
    expect_item(K_IDLE, 32'd1, "no_frames_after_reset");

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_mmio.md
# data_mem_mmio

Data-side memory subsystem that sits directly downstream of the pipelined core's MEM stage. It consumes the core's store strobe, store width, address and write data, and returns a 32-bit read word in the same cycle. It holds the data RAM with byte/half/word stores and a small MMIO window containing a UART transmitter with a TX FIFO. The core has no stall input, so every access completes without wait states.

## Interface
- RAM_WORDS, 4096: data RAM depth in 32-bit words; RAM covers byte addresses 0 .. RAM_WORDS*4-1.
- MMIO_BASE, 32'h1000_0000: base of the 16-byte MMIO window, decoded on addr[31:4].
- FIFO_DEPTH, 8: UART TX FIFO entries (power of two).
- CLKDIV_RESET, 16'd868: reset value of the baud divisor.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_write  in  1  store strobe from the core (ram_write).
- write_type  in  3  store width, funct3 encoding: 000 byte, 001 half, 010 word; other codes drop the store.
- mem_addr  in  32  byte address for both loads and stores.
- mem_write_data  in  32  store value, right-aligned in the low bits.
- mem_read_data  out  32  combinational read word.
- uart_tx  out  1  serial output, 8N1, idle high.

## Operation
- Decode:
  - RAM when mem_addr < RAM_WORDS*4.
  - MMIO when mem_addr[31:4] == MMIO_BASE[31:4].
  - Any other address reads 32'h0 and drops stores.
- RAM reads:
  - Return the full word at {addr[31:2],2'b00}.
  - Lane extraction and sign extension are the core's job.
- RAM stores:
  - The block shifts the low byte or half into the lane selected by addr[1:0] and writes only that lane.
  - Misaligned half (addr[0]=1) or word (addr[1:0]!=0) stores are dropped and set sticky ERR_ALIGN.
- MMIO offsets (addr[3:0]):
  - 0x0 TXDATA: a write pushes mem_write_data[7:0], any write_type. Reads return 0.
  - 0x4 STATUS, read-only fields: [0] fifo_full, [1] fifo_empty, [2] tx_busy, [3] ERR_ALIGN, [4] ERR_OVF, [11:8] fifo_count. Other bits are 0. Writing 1 to bit 3 or bit 4 clears that flag (W1C).
  - 0x8 CLKDIV: read/write, bits [15:0]. A written value of 0 is stored as 1.
  - 0xC: reads 0, writes are ignored.
- MMIO alignment: MMIO stores with addr[1:0]!=0 are dropped and set ERR_ALIGN.
- FIFO push rule: a push is accepted when count < FIFO_DEPTH, or when a pop occurs in the same cycle. Otherwise the push is dropped and ERR_OVF is set.
- Error-flag collision: if a W1C clear and a new error event for the same flag occur in the same cycle, the set wins.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START when the FIFO is non-empty. This pops one byte, latches CLKDIV into the bit timer, and drives uart_tx=0.
  - START -> DATA after CLKDIV cycles.
  - DATA sends 8 bits LSB first, each held CLKDIV cycles, tracked by a 3-bit bit counter.
  - DATA -> STOP after bit 7.
  - STOP drives uart_tx=1 for CLKDIV cycles, then returns to IDLE.
  - tx_busy = (state != IDLE).
- A CLKDIV write mid-frame takes effect at the next START.

## Timing
- Reset (rst low, asynchronous):
  - uart_tx=1, FSM IDLE, FIFO empty (count 0), CLKDIV=CLKDIV_RESET, ERR_ALIGN=ERR_OVF=0.
  - RAM contents are not reset.
  - mem_read_data stays combinational from the current address.
- Reset mid-frame aborts the frame immediately: uart_tx returns to 1 asynchronously and the FIFO contents are discarded.
- Latency:
  - Reads are combinational: zero cycles.
  - Stores and register writes commit at the rising edge where mem_write=1.
  - A read of the same address in the next cycle returns the new value.
- TXDATA latency:
  - A TXDATA write at edge N with the FSM idle gives uart_tx=0 after edge N+1.
  - A frame is exactly 10*CLKDIV cycles.
  - Back-to-back queued bytes have exactly one IDLE cycle (uart_tx=1) between the stop bit and the next start bit.
- STATUS reads reflect register state before the current edge; same-cycle pushes and pops become visible next cycle.

## Structure
- Shared package mem_map_pkg:
  - MMIO offset constants.
  - write_type encodings (WT_BYTE, WT_HALF, WT_WORD).
  - STATUS bit indices.
  - TX FSM state enum.
- One sub-module, uart_tx_core: FIFO, divisor latch, bit timer, bit counter and FSM.
- The top level holds the RAM, the address decode, the store lane logic and the status/error registers.

## Test plan
- SW 32'hDEADBEEF at 0x100, then SB 8'h55 at 0x102 -> read of 0x100 returns 32'hDE55BEEF.
- SH 16'h1234 at 0x101 -> word at 0x100 unchanged; STATUS bit3=1. Write 0x8 to STATUS -> bit3 reads 0.
- CLKDIV=4, TXDATA=8'hA5 -> uart_tx low for 4 cycles starting after the next edge. Data bits 1,0,1,0,0,1,0,1, each 4 cycles, then 4 cycles high. tx_busy high for 40 cycles.
- CLKDIV=2, 9 TXDATA writes in 9 consecutive cycles -> 8 accepted, 9th dropped, ERR_OVF=1, fifo_count=8. Exactly 8 frames appear, each separated by one idle cycle.
- Reset asserted mid-DATA with 3 bytes queued -> uart_tx=1 immediately. After release: STATUS shows fifo_empty=1, tx_busy=0, CLKDIV reads 868.
- Store to 0x2000_0000 -> no RAM change; read returns 0.
